riscv_irq_arbiter: RTL and testbench
====================================

# riscv_irq_arbiter

Interrupt source arbiter in front of the core's interrupt controller. It captures rising edges on 32 external/peripheral interrupt lines (plus software-set requests) into a pending register, applies an enable mask, and selects one winner by fixed priority. It offers the winner on a stable irq/id/sec triple that feeds the controller's `irq_i`/`irq_id_i`/`irq_sec_i` inputs, then retires the winner's pending bit on the core's acknowledge.

## Interface
- `NUM_IRQ`, 32: number of interrupt lines. Fixed at 32, matching the 5-bit id.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `irq_lines_i` in 32: raw interrupt lines. Rising-edge sensitive.
- `irq_mask_i` in 32: per-line enable. 1 = may be offered.
- `irq_sec_mask_i` in 32: per-line secure attribute, copied to `irq_sec_o`.
- `sw_set_i` in 1: software pend strobe.
- `sw_set_id_i` in 5: line set by `sw_set_i`.
- `irq_o` out 1: request to the interrupt controller.
- `irq_id_o` out 5: id of the offered line.
- `irq_sec_o` out 1: secure bit of the offered line.
- `irq_ack_i` in 1: core has taken the interrupt (one-cycle pulse).
- `irq_ack_id_i` in 5: id being acknowledged.
- `pending_o` out 32: raw pending register, before masking.

## Operation
- Edge capture:
  - `lines_q` registers `irq_lines_i`; an edge is `irq_lines_i & ~lines_q`.
  - `lines_q` resets to 0, so a line already high at reset release pends once.
- Pending update, every cycle: `pend_next = (pend & ~ack_clr) | edge | sw_set`.
  - `ack_clr` is the one-hot of `irq_ack_id_i`, applied only when `irq_ack_i` is high in OFFER.
  - A set and a clear of the same bit in the same cycle leaves the bit set: the new event wins.
- Candidates are `pend & irq_mask_i`. Lowest index wins (id 0 has highest priority).
- FSM states: IDLE, OFFER, GAP.
  - IDLE → OFFER when any candidate exists. Latch winner into `id_q` and `irq_sec_mask_i[winner]` into `sec_q`.
  - OFFER holds `irq_o=1`. `id_q`/`sec_q` are frozen; a higher-priority arrival does not preempt the offer.
  - OFFER → GAP on `irq_ack_i`. The bit cleared is `irq_ack_id_i`, whatever `id_q` holds.
  - OFFER → IDLE (withdraw) if `irq_mask_i[id_q]` drops or `pend[id_q]` is clear and no ack arrives.
  - GAP → IDLE unconditionally. This gives the controller's IDLE/PENDING/DONE sequence time to settle.
- Outputs:
  - `irq_o = (state==OFFER)`.
  - `irq_id_o = id_q` and `irq_sec_o = sec_q` in every state.
- An ack outside OFFER is ignored: no bit is cleared, no state change.
- Reset values: state=IDLE, `pend=0`, `lines_q=0`, `id_q=0`, `sec_q=0`. So `irq_o=0`, `irq_id_o=0`, `irq_sec_o=0`, `pending_o=0`.
- Reset mid-offer drops `irq_o` immediately (asynchronous) and loses every pending event.

## Timing
- Line rises at cycle N:
  - `pend` bit set at N+1.
  - IDLE sees the candidate at N+1; `irq_o`/`irq_id_o` valid at N+2.
- Minimum edge-to-request latency is 2 cycles.
- Ack in cycle M:
  - pending bit clear at M+1 and state GAP at M+1.
  - IDLE at M+2; next offer earliest at M+3.
- Withdraw: mask drop at cycle K gives `irq_o=0` at K+1.
- `pending_o` is registered and reflects an edge one cycle after it occurs.
- Ids and masks are sampled only on clock edges. No combinational path from any input to `irq_o`.

## Structure
- `riscv_defines` holds:
  - the `IRQ_ID_WIDTH=5` constant;
  - the arbiter state enum `irq_arb_state_e` (IDLE, OFFER, GAP).
- One sub-module, `riscv_irq_prio_enc`: a 32-bit lowest-set-bit finder. Outputs a 5-bit index and a valid flag; purely combinational.
- Top level holds the edge detector, pending register, FSM and output registers.

## Test plan
- Reset, then pulse line 7 with mask=all-ones → `pending_o[7]` set at +1, `irq_o=1` with `irq_id_o=7` at +2. Ack id 7 → `pend[7]` clears; `irq_o` low for 2 cycles.
- Edges on lines 3 and 12 in the same cycle → offer id 3. Ack 3, then offer id 12 three cycles after the ack.
- While offering id 12, pulse line 1 → id stays 12 until ack; then id 1 is offered.
- Offer id 5, then clear `irq_mask_i[5]` → `irq_o=0` next cycle and `pend[5]` retained. Re-enable → offer id 5 again.
- `sw_set_i` with id 9 in the same cycle as ack of id 9 → `pend[9]` remains 1 and id 9 is re-offered after GAP. `sec_mask[9]=1` → `irq_sec_o=1`.
- Assert `rst_n=0` mid-offer → `irq_o`, `irq_id_o`, `irq_sec_o` and `pending_o` go 0 immediately. A line held high through reset pends once after release.

Source files
------------

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared constants and arbiter state type
package riscv_defines;

   localparam int IRQ_ID_WIDTH  = 5;
   localparam int IRQ_NUM_LINES = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      GAP   = 2'd2
   } irq_arb_state_e;

endpackage

// File: rtl/riscv_irq_arbiter_if.sv
// rtl/riscv_irq_arbiter_if.sv - request/acknowledge link between arbiter and interrupt controller
interface riscv_irq_arbiter_if;
   import riscv_defines::*;

   logic                    irq;
   logic [IRQ_ID_WIDTH-1:0] irq_id;
   logic                    irq_sec;
   logic                    irq_ack;
   logic [IRQ_ID_WIDTH-1:0] irq_ack_id;

   modport master (
      output irq,
      output irq_id,
      output irq_sec,
      input  irq_ack,
      input  irq_ack_id
   );

   modport slave (
      input  irq,
      input  irq_id,
      input  irq_sec,
      output irq_ack,
      output irq_ack_id
   );

endinterface

// File: rtl/riscv_irq_prio_enc.sv
// rtl/riscv_irq_prio_enc.sv - lowest-set-bit finder, index 0 has highest priority
module riscv_irq_prio_enc
   import riscv_defines::*;
(
   input  logic [IRQ_NUM_LINES-1:0] req_i,
   output logic [IRQ_ID_WIDTH-1:0]  idx_o,
   output logic                     valid_o
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx_o = '0;
      for (int i = IRQ_NUM_LINES - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IRQ_ID_WIDTH'(i);
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/riscv_irq_arbiter.sv
// rtl/riscv_irq_arbiter.sv - edge capture, pending register and fixed-priority offer FSM
module riscv_irq_arbiter
   import riscv_defines::*;
#(
   parameter int NUM_IRQ = IRQ_NUM_LINES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IRQ-1:0]      irq_lines_i,
   input  logic [NUM_IRQ-1:0]      irq_mask_i,
   input  logic [NUM_IRQ-1:0]      irq_sec_mask_i,
   input  logic                    sw_set_i,
   input  logic [IRQ_ID_WIDTH-1:0] sw_set_id_i,
   riscv_irq_arbiter_if.master     ctrl,
   output logic [NUM_IRQ-1:0]      pending_o
);

   irq_arb_state_e          state_q;
   logic [NUM_IRQ-1:0]      lines_q;
   logic [NUM_IRQ-1:0]      pend_q;
   logic [NUM_IRQ-1:0]      pend_d;
   logic [NUM_IRQ-1:0]      edge_v;
   logic [NUM_IRQ-1:0]      sw_vec;
   logic [NUM_IRQ-1:0]      ack_clr;
   logic [NUM_IRQ-1:0]      cand;
   logic [IRQ_ID_WIDTH-1:0] id_q;
   logic [IRQ_ID_WIDTH-1:0] win_id;
   logic                    win_valid;
   logic                    sec_q;
   logic                    irq_q;

   // Setting terms are OR-ed after the clear so a same-cycle new event survives an ack.
   always_comb begin
      edge_v  = irq_lines_i & ~lines_q;
      sw_vec  = '0;
      ack_clr = '0;
      if (sw_set_i) begin
         sw_vec[sw_set_id_i] = 1'b1;
      end
      if (state_q == OFFER && ctrl.irq_ack) begin
         ack_clr[ctrl.irq_ack_id] = 1'b1;
      end
      pend_d = (pend_q & ~ack_clr) | edge_v | sw_vec;
      cand   = pend_q & irq_mask_i;
   end

   riscv_irq_prio_enc u_prio_enc (
      .req_i   (cand),
      .idx_o   (win_id),
      .valid_o (win_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lines_q <= '0;
         pend_q  <= '0;
         id_q    <= '0;
         sec_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         lines_q <= irq_lines_i;
         pend_q  <= pend_d;
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  state_q <= OFFER;
                  irq_q   <= 1'b1;
                  id_q    <= win_id;
                  sec_q   <= irq_sec_mask_i[win_id];
               end
            end
            OFFER: begin
               if (ctrl.irq_ack) begin
                  state_q <= GAP;
                  irq_q   <= 1'b0;
               end else if (!irq_mask_i[id_q] || !pend_q[id_q]) begin
                  state_q <= IDLE;
                  irq_q   <= 1'b0;
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ctrl.irq     = irq_q;
   assign ctrl.irq_id  = id_q;
   assign ctrl.irq_sec = sec_q;
   assign pending_o    = pend_q;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// tb/tb_riscv_irq_arbiter.sv - vector table, corner sequences and random run against a reference model
module tb_riscv_irq_arbiter;
   import riscv_defines::*;

   localparam logic [31:0] FULL = 32'hFFFF_FFFF;
   localparam logic [31:0] NO5  = 32'hFFFF_FFDF;

   typedef struct {
      logic [31:0] lines;
      logic [31:0] mask;
      logic        sw;
      logic [4:0]  sw_id;
      logic        ack;
      logic [4:0]  ack_id;
      logic        e_irq;
      logic [4:0]  e_id;
      logic        e_sec;
      logic [31:0] e_pend;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lines;
   logic [31:0] mask;
   logic [31:0] secm;
   logic        sw;
   logic [4:0]  sw_id;
   logic [31:0] pend_w;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [31:0] m_pend;
   logic [31:0] m_prev;
   bit          m_off;
   bit          m_gap;
   bit          m_sec;
   int          m_id;

   vec_t tbl[$];

   always #5 clk = ~clk;

   riscv_irq_arbiter_if bus ();

   riscv_irq_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_lines_i    (lines),
      .irq_mask_i     (mask),
      .irq_sec_mask_i (secm),
      .sw_set_i       (sw),
      .sw_set_id_i    (sw_id),
      .ctrl           (bus),
      .pending_o      (pend_w)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int lowest(input logic [31:0] v);
      for (int i = 0; i < 32; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic vec_t mk(input logic [31:0] l, input logic [31:0] m, input logic s,
                               input logic [4:0] sid, input logic a, input logic [4:0] aid,
                               input logic ei, input logic [4:0] eid, input logic es,
                               input logic [31:0] ep);
      vec_t v;
      v.lines = l;  v.mask = m;  v.sw = s;  v.sw_id = sid;  v.ack = a;  v.ack_id = aid;
      v.e_irq = ei; v.e_id = eid; v.e_sec = es; v.e_pend = ep;
      return v;
   endfunction

   task automatic model_reset();
      m_pend = '0;
      m_prev = '0;
      m_off  = 1'b0;
      m_gap  = 1'b0;
      m_sec  = 1'b0;
      m_id   = 0;
   endtask

   // One clock: predict from the inputs presented now, then compare just after the edge.
   task automatic step();
      logic [31:0] ev;
      logic [31:0] clr;
      bit          n_off;
      bit          n_gap;
      bit          n_sec;
      int          n_id;
      int          w;
      ev = lines & ~m_prev;
      if (sw) ev[sw_id] = 1'b1;
      clr   = '0;
      n_off = m_off;
      n_gap = 1'b0;
      n_id  = m_id;
      n_sec = m_sec;
      if (m_off) begin
         if (bus.irq_ack) begin
            clr[bus.irq_ack_id] = 1'b1;
            n_off = 1'b0;
            n_gap = 1'b1;
         end else if (!mask[m_id] || !m_pend[m_id]) begin
            n_off = 1'b0;
         end
      end else if (!m_gap) begin
         w = lowest(m_pend & mask);
         if (w >= 0) begin
            n_off = 1'b1;
            n_id  = w;
            n_sec = secm[w];
         end
      end
      @(posedge clk);
      #1;
      m_pend = (m_pend & ~clr) | ev;
      m_prev = lines;
      m_off  = n_off;
      m_gap  = n_gap;
      m_id   = n_id;
      m_sec  = n_sec;
      chk("model_irq",  32'(bus.irq),     32'(m_off));
      chk("model_id",   32'(bus.irq_id),  32'(m_id));
      chk("model_sec",  32'(bus.irq_sec), 32'(m_sec));
      chk("model_pend", pend_w,           m_pend);
   endtask

   initial begin
      rst_n          = 1'b0;
      lines          = '0;
      mask           = FULL;
      secm           = 32'h0000_0200;
      sw             = 1'b0;
      sw_id          = '0;
      bus.irq_ack    = 1'b0;
      bus.irq_ack_id = '0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk("reset_irq",  32'(bus.irq),     32'd0);
      chk("reset_id",   32'(bus.irq_id),  32'd0);
      chk("reset_sec",  32'(bus.irq_sec), 32'd0);
      chk("reset_pend", pend_w,           32'd0);
      rst_n = 1'b1;

      //            lines         mask  sw sid ack aid  irq id sec pend
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 0, 0, 32'h0));
      tbl.push_back(mk(32'h80,    FULL, 0, 0, 0, 0,   0, 0, 0, 32'h80));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 7, 0, 32'h80));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 7,   0, 7, 0, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 7, 0, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 7, 0, 32'h0));
      tbl.push_back(mk(32'h1008,  FULL, 0, 0, 0, 0,   0, 7, 0, 32'h1008));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 3, 0, 32'h1008));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 3,   0, 3, 0, 32'h1000));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 3, 0, 32'h1000));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 12, 0, 32'h1000));
      tbl.push_back(mk(32'h2,     FULL, 0, 0, 0, 0,   1, 12, 0, 32'h1002));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 12, 0, 32'h1002));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 12,  0, 12, 0, 32'h2));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 12, 0, 32'h2));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 1, 0, 32'h2));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 1,   0, 1, 0, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 1, 0, 32'h0));
      tbl.push_back(mk(32'h20,    FULL, 0, 0, 0, 0,   0, 1, 0, 32'h20));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 5, 0, 32'h20));
      tbl.push_back(mk(32'h0,     NO5,  0, 0, 0, 0,   0, 5, 0, 32'h20));
      tbl.push_back(mk(32'h0,     NO5,  0, 0, 0, 0,   0, 5, 0, 32'h20));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 5, 0, 32'h20));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 5,   0, 5, 0, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 5, 0, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 1, 9, 0, 0,   0, 5, 0, 32'h200));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 9, 1, 32'h200));
      tbl.push_back(mk(32'h0,     FULL, 1, 9, 1, 9,   0, 9, 1, 32'h200));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 9, 1, 32'h200));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 9, 1, 32'h200));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 9,   0, 9, 1, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 9, 1, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 1, 4, 1, 4,   0, 9, 1, 32'h10));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 4,   1, 4, 0, 32'h10));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 2,   0, 4, 0, 32'h10));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 4, 0, 32'h10));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   1, 4, 0, 32'h10));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 1, 4,   0, 4, 0, 32'h0));
      tbl.push_back(mk(32'h0,     FULL, 0, 0, 0, 0,   0, 4, 0, 32'h0));

      foreach (tbl[i]) begin
         lines          = tbl[i].lines;
         mask           = tbl[i].mask;
         sw             = tbl[i].sw;
         sw_id          = tbl[i].sw_id;
         bus.irq_ack    = tbl[i].ack;
         bus.irq_ack_id = tbl[i].ack_id;
         step();
         chk($sformatf("row%0d_irq", i),  32'(bus.irq),     32'(tbl[i].e_irq));
         chk($sformatf("row%0d_id", i),   32'(bus.irq_id),  32'(tbl[i].e_id));
         chk($sformatf("row%0d_sec", i),  32'(bus.irq_sec), 32'(tbl[i].e_sec));
         chk($sformatf("row%0d_pend", i), pend_w,           tbl[i].e_pend);
      end
      sw          = 1'b0;
      bus.irq_ack = 1'b0;

      // Reset in the middle of an offer, with line 6 held high throughout.
      secm  = 32'h0000_0240;
      lines = 32'h40;
      step();
      chk("rst_pre_pend", pend_w, 32'h40);
      step();
      chk("rst_pre_irq", 32'(bus.irq),    32'd1);
      chk("rst_pre_id",  32'(bus.irq_id), 32'd6);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_async_irq",  32'(bus.irq),     32'd0);
      chk("rst_async_id",   32'(bus.irq_id),  32'd0);
      chk("rst_async_sec",  32'(bus.irq_sec), 32'd0);
      chk("rst_async_pend", pend_w,           32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("rst_held_pend", pend_w, 32'h40);
      chk("rst_held_irq",  32'(bus.irq), 32'd0);
      step();
      chk("rst_held_offer", 32'(bus.irq),     32'd1);
      chk("rst_held_sec",   32'(bus.irq_sec), 32'd1);
      bus.irq_ack    = 1'b1;
      bus.irq_ack_id = 5'd6;
      step();
      bus.irq_ack = 1'b0;
      repeat (3) step();
      chk("rst_once_pend", pend_w, 32'h0);
      chk("rst_once_irq",  32'(bus.irq), 32'd0);

      // Random traffic against the model.
      secm = $urandom;
      for (int n = 0; n < 3000; n++) begin
         lines = lines ^ ($urandom & $urandom & $urandom);
         if ($urandom_range(0, 19) == 0) mask = ($urandom_range(0, 1) == 0) ? FULL : $urandom;
         if ($urandom_range(0, 99) == 0) secm = $urandom;
         sw    = ($urandom_range(0, 7) == 0);
         sw_id = 5'($urandom_range(0, 31));
         if (m_off && $urandom_range(0, 3) == 0) begin
            bus.irq_ack    = 1'b1;
            bus.irq_ack_id = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'(m_id);
         end else begin
            bus.irq_ack    = ($urandom_range(0, 15) == 0);
            bus.irq_ack_id = 5'($urandom_range(0, 31));
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
